pll_reset_ctrl: RTL and testbench

Reset and lock sequencer for the core PLL wrapper. It runs on the free-running PLL reference clock. It holds the PLL in reset for a fixed interval, waits for lock with a timeout and bounded retries, and requires lock to be stable before releasing the core reset. It also monitors for lock loss in operation and restarts the sequence when lock drops. It sits between the board clock/reset inputs and the PLL instance, and drives the PLL `rst` input and the core-wide reset.

---
 rtl/pll_reset_ctrl_pkg.sv | 33 +++
 rtl/sync_2ff.sv | 30 +++
 rtl/pll_reset_ctrl.sv | 179 +++++++++++++++++
 tb/tb_pll_reset_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pll_reset_ctrl_pkg.sv
// pll_reset_ctrl_pkg
// Shared definitions for the PLL reset/lock sequencer: sequencer state
// encoding, default cycle constants for a 50 MHz reference clock and a
// small helper used to size the shared cycle counter.
package pll_reset_ctrl_pkg;

   typedef enum logic [2:0] {
      RESET_PLL = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      RUN       = 3'd3,
      FAIL      = 3'd4
   } state_t;

   // Defaults for a 50 MHz refclk.
   // The hold of 100 cycles is 2 us; the lock timeout of 50000 cycles is 1 ms.
   localparam int DEF_RST_HOLD_CYCLES     = 100;
   localparam int DEF_LOCK_TIMEOUT_CYCLES = 50000;
   localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
   localparam int DEF_MAX_RETRIES         = 3;

   localparam logic [7:0] LOSS_CNT_MAX = 8'hFF;

   // Largest of three cycle counts. The result is floored at 2 so that the
   // derived counter width is never zero.
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      m = (m > c) ? m : c;
      return (m < 2) ? 2 : m;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
// Generic two-flop single-bit synchronizer with asynchronous active-high
// reset. Both flops reset to 0.
//   i_clk : destination clock
//   i_rst : asynchronous active-high reset
//   i_d   : asynchronous input bit
//   o_q   : synchronized output, two i_clk edges after i_d changes
module sync_2ff (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/pll_reset_ctrl.sv
// pll_reset_ctrl
// PLL reset and lock sequencer running on the PLL reference clock.
// The sequencer pulses the PLL reset, then waits for lock. A timeout
// triggers a bounded number of retries. Lock must then hold steadily
// before the core reset is released. A lock loss while running restarts
// the whole sequence.
//   refclk          : free-running PLL reference clock
//   rst             : asynchronous active-high reset
//   locked          : PLL lock indication, asynchronous to refclk
//   restart_req     : single-cycle request to rerun the full sequence
//   pll_rst         : PLL reset output
//   sys_rst         : core reset in the refclk domain
//   ready           : PLL locked and stable, core running
//   fail            : retries exhausted
//   retry_count     : retries used in the current sequence
//   lock_loss_count : saturating count of lock losses while running
module pll_reset_ctrl
   import pll_reset_ctrl_pkg::*;
#(
   parameter int RST_HOLD_CYCLES     = DEF_RST_HOLD_CYCLES,
   parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
   parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
   parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
   input  logic                               refclk,
   input  logic                               rst,
   input  logic                               locked,
   input  logic                               restart_req,
   output logic                               pll_rst,
   output logic                               sys_rst,
   output logic                               ready,
   output logic                               fail,
   output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count,
   output logic [7:0]                         lock_loss_count
);

   localparam int RC_W  = $clog2(MAX_RETRIES + 1);
   localparam int CNT_W = $clog2(max3(RST_HOLD_CYCLES, LOCK_TIMEOUT_CYCLES,
                                      LOCK_STABLE_CYCLES));

   localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [RC_W-1:0]  RETRY_LAST   = RC_W'(MAX_RETRIES);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic [RC_W-1:0]   r_retry;
   logic [7:0]        r_loss;
   logic              r_pll_rst;
   logic              r_sys_rst;
   logic              r_ready;
   logic              r_fail;

   logic              w_locked_s;
   logic              w_cnt_clr;
   logic              w_cnt_inc;
   logic              w_retry_inc;
   logic              w_retry_clr;
   logic              w_loss_inc;

   sync_2ff u_lock_sync (
      .i_clk (refclk),
      .i_rst (rst),
      .i_d   (locked),
      .o_q   (w_locked_s)
   );

   // Every state change clears the shared counter.
   // restart_req overrides all other transitions.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_clr   = 1'b0;
      w_cnt_inc   = 1'b0;
      w_retry_inc = 1'b0;
      w_retry_clr = 1'b0;
      w_loss_inc  = 1'b0;

      if (restart_req) begin
         w_state_nxt = RESET_PLL;
         w_cnt_clr   = 1'b1;
         w_retry_clr = 1'b1;
      end else begin
         case (r_state)
            RESET_PLL: begin
               if (r_cnt == HOLD_LAST) begin
                  w_state_nxt = WAIT_LOCK;
                  w_cnt_clr   = 1'b1;
               end else begin
                  w_cnt_inc   = 1'b1;
               end
            end
            WAIT_LOCK: begin
               if (w_locked_s) begin
                  w_state_nxt = STABLE;
                  w_cnt_clr   = 1'b1;
               end else if (r_cnt == TIMEOUT_LAST) begin
                  w_cnt_clr   = 1'b1;
                  if (r_retry == RETRY_LAST) begin
                     w_state_nxt = FAIL;
                  end else begin
                     w_state_nxt = RESET_PLL;
                     w_retry_inc = 1'b1;
                  end
               end else begin
                  w_cnt_inc   = 1'b1;
               end
            end
            STABLE: begin
               // A dropout sends the sequencer back to WAIT_LOCK with a fresh
               // timeout. This does not count as a retry.
               if (!w_locked_s) begin
                  w_state_nxt = WAIT_LOCK;
                  w_cnt_clr   = 1'b1;
               end else if (r_cnt == STABLE_LAST) begin
                  w_state_nxt = RUN;
                  w_cnt_clr   = 1'b1;
               end else begin
                  w_cnt_inc   = 1'b1;
               end
            end
            RUN: begin
               if (!w_locked_s) begin
                  w_state_nxt = RESET_PLL;
                  w_cnt_clr   = 1'b1;
                  w_retry_clr = 1'b1;
                  w_loss_inc  = 1'b1;
               end
            end
            FAIL: begin
               w_state_nxt = FAIL;
            end
            default: begin
               w_state_nxt = RESET_PLL;
               w_cnt_clr   = 1'b1;
            end
         endcase
      end
   end

   // Outputs are decoded from the next state so that they change on the
   // same edge as the state itself.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         r_state   <= RESET_PLL;
         r_cnt     <= '0;
         r_retry   <= '0;
         r_loss    <= '0;
         r_pll_rst <= 1'b1;
         r_sys_rst <= 1'b1;
         r_ready   <= 1'b0;
         r_fail    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;

         if (w_cnt_clr)      r_cnt <= '0;
         else if (w_cnt_inc) r_cnt <= r_cnt + CNT_W'(1);

         if (w_retry_clr)      r_retry <= '0;
         else if (w_retry_inc) r_retry <= r_retry + RC_W'(1);

         if (w_loss_inc && (r_loss != LOSS_CNT_MAX)) r_loss <= r_loss + 8'd1;

         r_pll_rst <= (w_state_nxt == RESET_PLL) || (w_state_nxt == FAIL);
         r_sys_rst <= (w_state_nxt != RUN);
         r_ready   <= (w_state_nxt == RUN);
         r_fail    <= (w_state_nxt == FAIL);
      end
   end

   assign pll_rst         = r_pll_rst;
   assign sys_rst         = r_sys_rst;
   assign ready           = r_ready;
   assign fail            = r_fail;
   assign retry_count     = r_retry;
   assign lock_loss_count = r_loss;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// tb_pll_reset_ctrl
// Scoreboard bench for pll_reset_ctrl with short cycle parameters.
// Expected output vectors are queued with the refclk edge number at which
// they must hold. These vectors are derived from the sequencer timing.
// A negedge monitor pops the vectors and compares them.
module tb_pll_reset_ctrl;

   localparam int H = 4;
   localparam int T = 20;
   localparam int S = 8;
   localparam int R = 2;

   logic       refclk = 1'b0;
   logic       rst = 1'b1;
   logic       locked = 1'b0;
   logic       restart_req = 1'b0;
   logic       pll_rst;
   logic       sys_rst;
   logic       ready;
   logic       fail;
   logic [1:0] retry_count;
   logic [7:0] lock_loss_count;

   pll_reset_ctrl #(
      .RST_HOLD_CYCLES     (H),
      .LOCK_TIMEOUT_CYCLES (T),
      .LOCK_STABLE_CYCLES  (S),
      .MAX_RETRIES         (R)
   ) dut (
      .refclk          (refclk),
      .rst             (rst),
      .locked          (locked),
      .restart_req     (restart_req),
      .pll_rst         (pll_rst),
      .sys_rst         (sys_rst),
      .ready           (ready),
      .fail            (fail),
      .retry_count     (retry_count),
      .lock_loss_count (lock_loss_count)
   );

   always #5 refclk = ~refclk;

   // Number of refclk edges since rst was released
   int cyc;
   always @(posedge refclk or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   typedef struct {
      string       tag;
      int          at;
      logic [15:0] v;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   logic [15:0] w_obs;
   assign w_obs = {2'b00, pll_rst, sys_rst, ready, fail, retry_count, lock_loss_count};

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%04h expected 0x%04h (cyc %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [15:0] ev(input bit pr, input bit sr, input bit rd,
                                      input bit fl, input logic [1:0] rc,
                                      input logic [7:0] ll);
      return {2'b00, pr, sr, rd, fl, rc, ll};
   endfunction

   task automatic push(input string tag, input int at, input logic [15:0] v);
      exp_t e;
      e.tag = tag;
      e.at  = at;
      e.v   = v;
      sb.push_back(e);
   endtask

   always @(negedge refclk) begin
      while (sb.size() > 0 && sb[0].at <= cyc) begin
         exp_t e;
         e = sb.pop_front();
         chk(e.tag, w_obs, e.v);
      end
   end

   // Returns just after edge k, away from both clock edges.
   task automatic wait_edge(input int k);
      do begin
         @(posedge refclk);
         #2;
      end while (cyc < k);
   endtask

   task automatic rst_on(input logic lk);
      @(posedge refclk);
      #2;
      rst    = 1'b1;
      locked = lk;
      repeat (2) @(posedge refclk);
      #2;
   endtask

   task automatic drain();
      for (int n = 0; n < 200 && sb.size() > 0; n++) @(posedge refclk);
      chk("sb_drain", 16'(sb.size()), 16'd0);
   endtask

   task automatic wait_sysrst(input int lim);
      for (int n = 0; n < lim && sys_rst !== 1'b1; n++) @(negedge refclk);
      chk("wait_sysrst", {15'd0, sys_rst}, 16'd1);
   endtask

   task automatic wait_ready(input int lim);
      for (int n = 0; n < lim && ready !== 1'b1; n++) @(negedge refclk);
      chk("wait_ready", {15'd0, ready}, 16'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      // Never locks: three attempts of H+T edges each, then FAIL.
      rst_on(1'b0);
      push("nl_reset",   0, ev(1,1,0,0,0,0));
      push("nl_hold3",   3, ev(1,1,0,0,0,0));
      push("nl_rel4",    4, ev(0,1,0,0,0,0));
      push("nl_retry1", 24, ev(1,1,0,0,1,0));
      push("nl_rel28",  28, ev(0,1,0,0,1,0));
      push("nl_retry2", 48, ev(1,1,0,0,2,0));
      push("nl_rel52",  52, ev(0,1,0,0,2,0));
      push("nl_pre71",  71, ev(0,1,0,0,2,0));
      push("nl_fail72", 72, ev(1,1,0,1,2,0));
      push("nl_hold90", 90, ev(1,1,0,1,2,0));
      push("rs_req91",  91, ev(1,1,0,0,0,0));
      push("rs_rel95",  95, ev(0,1,0,0,0,0));
      push("rs_pre103",103, ev(0,1,0,0,0,0));
      push("rs_run104",104, ev(0,0,1,0,0,0));
      rst = 1'b0;
      wait_edge(90);
      restart_req = 1'b1;
      locked      = 1'b1;
      wait_edge(91);
      restart_req = 1'b0;
      drain();

      // Glitchy lock after one timed-out attempt.
      rst_on(1'b0);
      push("gl_reset",   0, ev(1,1,0,0,0,0));
      push("gl_retry1", 24, ev(1,1,0,0,1,0));
      push("gl_stable", 33, ev(0,1,0,0,1,0));
      push("gl_st38",   38, ev(0,1,0,0,1,0));
      push("gl_back39", 39, ev(0,1,0,0,1,0));
      push("gl_wait47", 47, ev(0,1,0,0,1,0));
      push("gl_pre55",  55, ev(0,1,0,0,1,0));
      push("gl_run56",  56, ev(0,0,1,0,1,0));
      rst = 1'b0;
      wait_edge(30);
      locked = 1'b1;
      wait_edge(36);
      locked = 1'b0;
      wait_edge(45);
      locked = 1'b1;
      drain();

      // Clean lock, then one lock loss with full resequence.
      rst_on(1'b1);
      push("cl_reset",   0, ev(1,1,0,0,0,0));
      push("cl_hold3",   3, ev(1,1,0,0,0,0));
      push("cl_rel4",    4, ev(0,1,0,0,0,0));
      push("cl_pre12",  12, ev(0,1,0,0,0,0));
      push("cl_run13",  13, ev(0,0,1,0,0,0));
      push("ll_run22",  22, ev(0,0,1,0,0,0));
      push("ll_loss23", 23, ev(1,1,0,0,0,1));
      push("ll_hold26", 26, ev(1,1,0,0,0,1));
      push("ll_rel27",  27, ev(0,1,0,0,0,1));
      push("ll_pre35",  35, ev(0,1,0,0,0,1));
      push("ll_run36",  36, ev(0,0,1,0,0,1));
      rst = 1'b0;
      wait_edge(20);
      locked = 1'b0;
      wait_edge(23);
      locked = 1'b1;
      drain();

      // 300 further losses saturate the loss counter.
      @(negedge refclk);
      for (int i = 0; i < 300; i++) begin
         locked = 1'b0;
         wait_sysrst(10);
         locked = 1'b1;
         wait_ready(40);
      end
      push("ll_sat", cyc + 1, ev(0,0,1,0,0,8'd255));
      drain();

      // Asynchronous reset in the middle of STABLE.
      @(negedge refclk);
      locked = 1'b0;
      wait_sysrst(10);
      locked = 1'b1;
      repeat (8) @(negedge refclk);
      chk("st_notready", {15'd0, ready}, 16'd0);
      rst = 1'b1;
      #1;
      chk("async_rst", w_obs, ev(1,1,0,0,0,0));
      rst_on(1'b1);
      push("ar_reset",  0, ev(1,1,0,0,0,0));
      push("ar_rel4",   4, ev(0,1,0,0,0,0));
      push("ar_run13", 13, ev(0,0,1,0,0,0));
      rst = 1'b0;
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
